// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Imported by the fetch queue and the fetch unit top.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES   = 32'd4;
  localparam int unsigned QDEPTH       = 2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fq_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry prefetch FIFO of {inst, pc}; entry 0 is always the head.
// Flush dominates push and pop.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [31:0] push_inst,
  input  logic [31:0] push_pc,
  input  logic        pop,
  input  logic        flush,
  output logic [31:0] head_inst,
  output logic [31:0] head_pc,
  output logic [1:0]  count
);

  fq_entry_t ent0, ent1, din;
  logic [1:0] cnt;
  logic do_pop, do_push;

  assign din       = '{inst: push_inst, pc: push_pc};
  assign do_pop    = pop && (cnt != 2'd0);
  assign do_push   = push && ((cnt != 2'd2) || do_pop);
  assign head_inst = ent0.inst;
  assign head_pc   = ent0.pc;
  assign count     = cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent0 <= '0;
      ent1 <= '0;
      cnt  <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (cnt == 2'd0) ent0 <= din;
          else ent1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          // new entry lands behind whatever becomes the head
          if (cnt == 2'd1) begin
            ent0 <= din;
          end else begin
            ent0 <= ent1;
            ent1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding imem read, 2-entry prefetch queue,
// redirect flushes the queue and drops any stale response.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc4,
  input  logic        inst_ready
);

  localparam logic [1:0] QMAX = 2'(QDEPTH);

  fetch_state_t state, state_nxt;
  logic [31:0] fetch_pc, fetch_pc_nxt;
  logic [31:0] req_addr, req_addr_nxt;
  logic [31:0] target, head_pc;
  logic        stale, stale_nxt;
  logic        push, pop, issue_ok;
  logic [1:0]  cnt, cnt_after;

  assign target     = word_align(redirect_pc);
  assign inst_valid = (cnt != 2'd0);
  assign pop        = inst_valid & inst_ready;
  assign push       = (state == WAIT) & imem_rvalid & ~redirect_valid;
  assign cnt_after  = redirect_valid ? 2'd0
                    : cnt + {1'b0, push} - {1'b0, pop};
  assign issue_ok   = (cnt_after < QMAX);

  assign imem_req  = (state == REQ);
  assign imem_addr = req_addr;
  assign inst_pc   = head_pc;
  assign inst_pc4  = inst_valid ? head_pc + WORD_BYTES : '0;

  fetch_queue u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_inst (imem_rdata),
    .push_pc   (req_addr),
    .pop       (pop),
    .flush     (redirect_valid),
    .head_inst (inst),
    .head_pc   (head_pc),
    .count     (cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      stale    <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      req_addr <= req_addr_nxt;
      stale    <= stale_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    req_addr_nxt = req_addr;
    stale_nxt    = stale;
    unique case (state)
      IDLE: begin
        if (redirect_valid) begin
          fetch_pc_nxt = target;
        end else if (issue_ok) begin
          state_nxt    = REQ;
          req_addr_nxt = fetch_pc;
        end
      end
      REQ: begin
        if (imem_ack) begin
          stale_nxt = 1'b0;
          if (redirect_valid || stale) begin
            state_nxt = DROP;
            if (redirect_valid) fetch_pc_nxt = target;
          end else begin
            state_nxt    = WAIT;
            fetch_pc_nxt = fetch_pc + WORD_BYTES;
          end
        end else if (redirect_valid) begin
          // address must stay put until the memory accepts it
          stale_nxt    = 1'b1;
          fetch_pc_nxt = target;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          fetch_pc_nxt = target;
          state_nxt    = imem_rvalid ? IDLE : DROP;
        end else if (imem_rvalid) begin
          if (issue_ok) begin
            state_nxt    = REQ;
            req_addr_nxt = fetch_pc;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DROP: begin
        if (redirect_valid) fetch_pc_nxt = target;
        if (imem_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage sitting directly upstream of the single-cycle MIPS datapath/controller pair. Issues word-aligned instruction reads to an instruction memory with variable-latency handshake, buffers returned words in a 2-entry prefetch queue, and presents each instruction with its PC to the decode/execute side under valid/ready. Branch/jump redirects from the datapath flush the queue and discard any stale in-flight response.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- QDEPTH, 2, prefetch queue entries (fixed at 2 in this revision)
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous assert, active-low (0 = reset)
- redirect_valid  in  1  datapath taken branch/jump this cycle
- redirect_pc  in  32  new fetch target; bits [1:0] forced to 0
- imem_req  out  1  read request to instruction memory
- imem_addr  out  32  word-aligned request address
- imem_ack  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid (earliest the cycle after ack)
- imem_rdata  in  32  instruction word
- inst_valid  out  1  queue head holds an instruction
- inst  out  32  queue head instruction (opc = [31:26], func = [5:0])
- inst_pc  out  32  address of inst
- inst_pc4  out  32  inst_pc + 4, mod 2^32
- inst_ready  in  1  downstream consumes head when inst_valid & inst_ready

## Operation
- Registers: fetch_pc (next address), FSM state, queue (2 x {inst, pc}), count (0..2).
- At most one outstanding memory request. Issue allowed only when count + in_flight < 2; queue can never overflow.
- FSM states:
  - IDLE: imem_req=0. If issue allowed -> REQ.
  - REQ: imem_req=1, imem_addr=fetch_pc, both stable until imem_ack. On ack: fetch_pc += 4; -> WAIT (or DROP if stale flag set).
  - WAIT: on imem_rvalid: push {imem_rdata, request pc}; -> REQ if issue still allowed after push/pop, else IDLE.
  - DROP: on imem_rvalid: discard data; -> IDLE.
- Redirect (highest priority, any state): queue flushed (count=0), fetch_pc = {redirect_pc[31:2],2'b00}.
  - IDLE: -> IDLE (request starts next cycle).
  - REQ without ack: request held unchanged, stale flag set; ack -> DROP. REQ with ack same cycle: -> DROP, fetch_pc = redirect target (not +4).
  - WAIT without rvalid -> DROP; WAIT with rvalid same cycle: data discarded, -> IDLE.
  - DROP: fetch_pc updated, stays DROP.
- Same-cycle pop and push: count unchanged, new entry behind head. Same-cycle pop and redirect: redirect wins, count=0.
- PC arithmetic 32-bit unsigned, wraps 0xFFFF_FFFC -> 0x0000_0000.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, inst_pc4=0, state=IDLE, count=0.
- First imem_req=1 on the first rising edge after rst deasserts.
- Latency: ack in cycle N, rvalid in N+1 -> inst_valid=1 in N+2 (queue registered, no rdata bypass).
- Peak throughput with zero-wait memory: one instruction per 2 cycles.
- inst_valid, inst, inst_pc, inst_pc4 driven from registers only; no combinational path from inst_ready or redirect_valid to any output.
- inst/inst_pc held stable while inst_valid & !inst_ready.
- Reset mid-transaction: all state cleared immediately; any later rvalid for the aborted request is ignored (state IDLE).

## Structure
- Package fetch_pkg: state enum {IDLE, REQ, WAIT, DROP}, RESET_PC default, WORD_BYTES=4.
- Sub-module fetch_queue: 2-entry FIFO of {inst, pc} with push, pop, flush, count; flush dominates push.
- Top holds FSM, fetch_pc, stale flag, handshake logic.

## Test plan
- Reset release, memory acks immediately, rvalid next cycle, inst_ready=1 -> imem_addr 0,4,8,...; inst_pc 0x0 valid 2 cycles after first ack, one instruction every 2 cycles.
- inst_ready=0 for 10 cycles -> exactly 2 words fetched (0x0, 0x4), imem_req stays 0, head stable; release -> 0x0, 0x4 delivered in order, fetching resumes at 0x8.
- Redirect to 0x100 while in WAIT for 0x8 -> response for 0x8 dropped, next request 0x100, inst_pc 0x8 never appears.
- Redirect to 0x203 same cycle as ack of 0x10 -> next request 0x200, response for 0x10 discarded.
- imem_ack delayed 3 cycles -> imem_req/imem_addr stable through wait; redirect during wait -> original address still issued, its data dropped.
- fetch_pc 0xFFFF_FFFC -> inst_pc4=0x0, next request 0x0; rst pulse mid-WAIT -> outputs return to reset values, late rvalid ignored.
